mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register. It consumes that register's outputs and performs word, half or byte loads and stores against the data memory over a request/ready handshake. While an access is outstanding it stalls the upstream pipeline. Its registered outputs form the MEM/WB boundary feeding write-back.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access sizes, FSM
// states and byte-lane helpers.
package mem_stage_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Byte enables for an access of the given size at the given byte offset.
  // The illegal size code falls into the word case.
  function automatic logic [3:0] be_mask(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << addr_lo;
      SIZE_HALF: m = 4'b0011 << {addr_lo[1], 1'b0};
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  // Natural alignment check; bytes are always aligned.
  function automatic logic addr_aligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = (addr_lo[0] == 1'b0);
      default:   ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed lane(s) out of a memory word
// and sign- or zero-extends the result to 32 bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection, little-endian.
  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension to the full datapath width.
  always_comb begin
    result = rdata;
    case (size)
      SIZE_BYTE: result = is_unsigned ? {24'd0, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: result = is_unsigned ? {16'd0, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Issues word/half/byte loads and stores to
// the data memory over a req/ready handshake, stalls upstream while an
// access is outstanding and registers the MEM/WB boundary.
//
// state | meaning
// IDLE  | pass-through; an aligned memory op launches a request
// REQ   | request outstanding, EX/MEM held by stall until dmem_ready
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic              MemToReg_in,
  input  logic              jal_in,
  input  logic [1:0]        Size_in,
  input  logic              Unsigned_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] ReadData2_in,
  input  logic [4:0]        WriteReg_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              Stall_out,
  output logic              RegWrite_out,
  output logic              MemToReg_out,
  output logic              jal_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [4:0]        WriteReg_out,
  output logic              Misaligned_out
);

  state_t      state;
  logic        mem_op;
  logic        aligned;
  logic        start;
  logic        misaligned;
  logic        is_store;
  logic [31:0] load_data;

  assign mem_op     = MemRead_in | MemWrite_in;
  assign is_store   = MemWrite_in;
  assign aligned    = addr_aligned(Size_in, ALUResult_in[1:0]);
  assign start      = (state == IDLE) && mem_op && aligned;
  assign misaligned = (state == IDLE) && mem_op && !aligned;

  // Upstream holds EX/MEM from the launch cycle until ready is seen.
  assign Stall_out  = start || ((state == REQ) && !dmem_ready);

  // Request side is driven straight from the held EX/MEM inputs, so it is
  // stable for as long as the stall keeps those inputs frozen.
  assign dmem_req   = (state == REQ);
  assign dmem_we    = (state == REQ) && is_store;
  assign dmem_addr  = {ALUResult_in[31:2], 2'b00};
  assign dmem_be    = be_mask(Size_in, ALUResult_in[1:0]);

  // Store data replicated across every lane the access may land in.
  always_comb begin
    dmem_wdata = ReadData2_in;
    case (Size_in)
      SIZE_BYTE: dmem_wdata = {4{ReadData2_in[7:0]}};
      SIZE_HALF: dmem_wdata = {2{ReadData2_in[15:0]}};
      default:   dmem_wdata = ReadData2_in;
    endcase
  end

  mem_load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (ALUResult_in[1:0]),
    .size        (Size_in),
    .is_unsigned (Unsigned_in),
    .result      (load_data)
  );

  // Sequencer and MEM/WB register. A bubble (RegWrite/Misaligned low,
  // everything else held) is emitted on every edge the stage is busy.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= IDLE;
      RegWrite_out   <= 1'b0;
      MemToReg_out   <= 1'b0;
      jal_out        <= 1'b0;
      ReadData_out   <= '0;
      ALUResult_out  <= '0;
      WriteReg_out   <= '0;
      Misaligned_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= REQ;
            RegWrite_out   <= 1'b0;
            Misaligned_out <= 1'b0;
          end else begin
            // Non-memory op, or a faulting access that never reaches memory.
            RegWrite_out   <= RegWrite_in && !misaligned;
            Misaligned_out <= misaligned;
            MemToReg_out   <= MemToReg_in;
            jal_out        <= jal_in;
            ALUResult_out  <= ALUResult_in;
            WriteReg_out   <= WriteReg_in;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            state          <= IDLE;
            RegWrite_out   <= RegWrite_in;
            Misaligned_out <= 1'b0;
            MemToReg_out   <= MemToReg_in;
            jal_out        <= jal_in;
            ALUResult_out  <= ALUResult_in;
            WriteReg_out   <= WriteReg_in;
            if (!is_store) begin
              ReadData_out <= load_data;
            end
          end else begin
            RegWrite_out   <= 1'b0;
            Misaligned_out <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          RegWrite_out   <= 1'b0;
          Misaligned_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, half/byte loads, byte store,
// misaligned access, pass-through and back-to-back requests.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in, jal_in;
  logic [1:0]  Size_in;
  logic        Unsigned_in;
  logic [31:0] ALUResult_in, ReadData2_in;
  logic [4:0]  WriteReg_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        Stall_out, RegWrite_out, MemToReg_out, jal_out, Misaligned_out;
  logic [31:0] ReadData_out, ALUResult_out;
  logic [4:0]  WriteReg_out;

  int total = 0;
  int bad   = 0;
  int stall_cnt;

  always #5 Clk = ~Clk;

  mem_stage #(.DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .jal_in(jal_in),
    .Size_in(Size_in), .Unsigned_in(Unsigned_in),
    .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
    .WriteReg_in(WriteReg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .Stall_out(Stall_out), .RegWrite_out(RegWrite_out),
    .MemToReg_out(MemToReg_out), .jal_out(jal_out),
    .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
    .WriteReg_out(WriteReg_out), .Misaligned_out(Misaligned_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 ns past the edge.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic nop();
    MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; MemToReg_in = 0;
    jal_in = 0; Size_in = 2'b00; Unsigned_in = 0;
    ALUResult_in = 0; ReadData2_in = 0; WriteReg_in = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic op(input logic mr, input logic mw, input logic rw,
                    input logic [1:0] sz, input logic uns,
                    input logic [31:0] alu, input logic [31:0] rd2,
                    input logic [4:0] wr);
    MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw; MemToReg_in = mr;
    jal_in = 0; Size_in = sz; Unsigned_in = uns;
    ALUResult_in = alu; ReadData2_in = rd2; WriteReg_in = wr;
  endtask

  initial begin
    Rst = 1'b0;
    nop();
    #1;
    // ---- reset state
    chk("rst_req",    {31'd0, dmem_req},       32'd0);
    chk("rst_regw",   {31'd0, RegWrite_out},   32'd0);
    chk("rst_rdata",  ReadData_out,            32'd0);
    chk("rst_alu",    ALUResult_out,           32'd0);
    chk("rst_wreg",   {27'd0, WriteReg_out},   32'd0);
    chk("rst_mis",    {31'd0, Misaligned_out}, 32'd0);
    chk("rst_stall",  {31'd0, Stall_out},      32'd0);
    tick(); tick();
    Rst = 1'b1;

    // ---- non-memory op
    tick();
    op(0, 0, 1, 2'b00, 0, 32'h1234, 0, 5'd5);
    #1 chk("nm_stall", {31'd0, Stall_out}, 32'd0);
    tick();
    chk("nm_regw", {31'd0, RegWrite_out}, 32'd1);
    chk("nm_alu",  ALUResult_out,         32'h1234);
    chk("nm_wreg", {27'd0, WriteReg_out}, 32'd5);
    chk("nm_stall_after", {31'd0, Stall_out}, 32'd0);
    nop();

    // ---- half load 0x102 signed, two wait cycles
    tick();
    op(1, 0, 1, 2'b01, 0, 32'h102, 0, 5'd7);
    stall_cnt = 0;
    #1 if (Stall_out) stall_cnt++;
    chk("hl_c0_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("hl_req",  {31'd0, dmem_req}, 32'd1);
    chk("hl_addr", dmem_addr,         32'h100);
    chk("hl_be",   {28'd0, dmem_be},  32'hC);
    chk("hl_we",   {31'd0, dmem_we},  32'd0);
    chk("hl_bubble", {31'd0, RegWrite_out}, 32'd0);
    if (Stall_out) stall_cnt++;
    tick();
    chk("hl_req_hold", {31'd0, dmem_req}, 32'd1);
    if (Stall_out) stall_cnt++;
    dmem_ready = 1; dmem_rdata = 32'h8001_7FFF;
    #1 chk("hl_stall_rdy", {31'd0, Stall_out}, 32'd0);
    if (Stall_out) stall_cnt++;
    chk("hl_stall_cnt", stall_cnt, 32'd3);
    tick();
    nop();
    chk("hl_rdata", ReadData_out,         32'hFFFF_8001);
    chk("hl_regw",  {31'd0, RegWrite_out}, 32'd1);
    chk("hl_wreg",  {27'd0, WriteReg_out}, 32'd7);
    tick();
    chk("hl_regw_once", {31'd0, RegWrite_out}, 32'd0);
    chk("hl_rdata_hold", ReadData_out, 32'hFFFF_8001);

    // ---- byte store 0x203, ready immediately
    op(0, 1, 0, 2'b10, 0, 32'h203, 32'h0000_00A5, 5'd0);
    #1 chk("bs_stall0", {31'd0, Stall_out}, 32'd1);
    tick();
    dmem_ready = 1;
    #1;
    chk("bs_req",   {31'd0, dmem_req}, 32'd1);
    chk("bs_we",    {31'd0, dmem_we},  32'd1);
    chk("bs_be",    {28'd0, dmem_be},  32'h8);
    chk("bs_wdata", dmem_wdata,        32'hA5A5_A5A5);
    chk("bs_addr",  dmem_addr,         32'h200);
    chk("bs_stall1", {31'd0, Stall_out}, 32'd0);
    tick();
    nop();
    #1 chk("bs_done_req", {31'd0, dmem_req}, 32'd0);
    chk("bs_rdata_hold", ReadData_out, 32'hFFFF_8001);

    // ---- misaligned word load
    tick();
    op(1, 0, 1, 2'b00, 0, 32'h06, 0, 5'd3);
    #1 chk("mis_stall", {31'd0, Stall_out}, 32'd0);
    tick();
    chk("mis_flag", {31'd0, Misaligned_out}, 32'd1);
    chk("mis_regw", {31'd0, RegWrite_out},   32'd0);
    chk("mis_req",  {31'd0, dmem_req},       32'd0);
    nop();
    tick();
    chk("mis_pulse", {31'd0, Misaligned_out}, 32'd0);

    // ---- back-to-back unsigned byte loads
    op(1, 0, 1, 2'b10, 1, 32'h01, 0, 5'd9);
    #1 chk("bb_stall0", {31'd0, Stall_out}, 32'd1);
    tick();
    chk("bb_req1", {31'd0, dmem_req}, 32'd1);
    chk("bb_be1",  {28'd0, dmem_be},  32'h2);
    dmem_ready = 1; dmem_rdata = 32'h1122_3344;
    tick();
    chk("bb_rd1", ReadData_out, 32'h33);
    op(1, 0, 1, 2'b10, 1, 32'h02, 0, 5'd10);
    dmem_ready = 0;
    #1 chk("bb_gap", {31'd0, dmem_req}, 32'd0);
    chk("bb_gap_stall", {31'd0, Stall_out}, 32'd1);
    tick();
    chk("bb_req2", {31'd0, dmem_req}, 32'd1);
    chk("bb_be2",  {28'd0, dmem_be},  32'h4);
    dmem_ready = 1;
    tick();
    chk("bb_rd2",   ReadData_out,          32'h22);
    chk("bb_wreg2", {27'd0, WriteReg_out}, 32'd10);
    nop();

    // ---- reset in the middle of a waited request
    tick();
    op(1, 0, 1, 2'b00, 0, 32'h10, 0, 5'd4);
    tick();
    chk("rr_req", {31'd0, dmem_req}, 32'd1);
    Rst = 1'b0;
    #1;
    chk("rr_req_drop", {31'd0, dmem_req},     32'd0);
    chk("rr_rdata0",   ReadData_out,          32'd0);
    chk("rr_alu0",     ALUResult_out,         32'd0);
    chk("rr_regw0",    {31'd0, RegWrite_out}, 32'd0);
    chk("rr_stall_idle", {31'd0, Stall_out},  32'd1);
    dmem_ready = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rr_no_wb", {31'd0, RegWrite_out}, 32'd0);
    nop();
    Rst = 1'b1;
    tick();
    chk("rr_no_wb2", {31'd0, RegWrite_out}, 32'd0);
    chk("rr_idle_req", {31'd0, dmem_req}, 32'd0);
    op(0, 0, 1, 2'b00, 0, 32'h55, 0, 5'd2);
    tick();
    chk("rr_idle_pass", ALUResult_out, 32'h55);
    chk("rr_idle_regw", {31'd0, RegWrite_out}, 32'd1);
    nop();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
